// File: rtl/wb_writeback_seq.sv
// Writeback stage: selects the result and drives the GPR/FPR write port and HI/LO.
// A 64-bit result is written as two 32-bit writes (even reg, then odd reg).
module wb_writeback_seq #(
  parameter int DW       = 32,
  parameter int AW       = 5,
  parameter int LINK_REG = 31
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          reg_write,
  input  logic          mem_to_reg,
  input  logic          mem_to_reg64,
  input  logic          load_byte,
  input  logic          jal,
  input  logic          fp_write,
  input  logic          hilo_write,
  input  logic          write32_64,
  input  logic [AW-1:0] dest,
  input  logic [DW-1:0] alu_result,
  input  logic [DW-1:0] mem_data,
  input  logic [DW-1:0] link_addr,
  input  logic [63:0]   alu64,
  input  logic [63:0]   data64,
  output logic          gpr_we,
  output logic          fpr_we,
  output logic [AW-1:0] wr_addr,
  output logic [DW-1:0] wr_data,
  output logic [DW-1:0] hi_out,
  output logic [DW-1:0] lo_out,
  output logic          align_err
);

  typedef enum logic {IDLE, WR_HI} state_t;

  state_t        state;
  logic [DW-1:0] pend_hi;
  logic [AW-1:0] pend_addr;
  logic          pend_fp;
  logic          accept;
  logic [DW-1:0] sel32;
  logic [63:0]   sel64;

  assign in_ready = (state == IDLE);
  assign accept   = in_valid & in_ready;

  // jal is handled separately since it also overrides the address and file select
  always_comb begin
    sel32 = alu_result;
    if (load_byte)       sel32 = {{(DW-8){mem_data[7]}}, mem_data[7:0]};
    else if (mem_to_reg) sel32 = mem_data;
    sel64 = mem_to_reg64 ? data64 : alu64;
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state     <= IDLE;
      gpr_we    <= 1'b0;
      fpr_we    <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      hi_out    <= '0;
      lo_out    <= '0;
      align_err <= 1'b0;
      pend_hi   <= '0;
      pend_addr <= '0;
      pend_fp   <= 1'b0;
    end else begin
      gpr_we    <= 1'b0;
      fpr_we    <= 1'b0;
      align_err <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          if (hilo_write) begin
            hi_out <= alu64[63:32];
            lo_out <= alu64[31:0];
          end
          if (write32_64) begin
            if (dest[0]) begin
              align_err <= 1'b1;
            end else if (reg_write) begin
              wr_addr   <= dest;
              wr_data   <= sel64[DW-1:0];
              fpr_we    <= fp_write;
              gpr_we    <= !fp_write && (dest != '0);
              pend_hi   <= sel64[2*DW-1:DW];
              pend_addr <= dest | AW'(1);
              pend_fp   <= fp_write;
              state     <= WR_HI;
            end
          end else if (reg_write) begin
            if (jal) begin
              wr_addr <= AW'(LINK_REG);
              wr_data <= link_addr;
              gpr_we  <= 1'b1;
            end else begin
              wr_addr <= dest;
              wr_data <= sel32;
              fpr_we  <= fp_write;
              gpr_we  <= !fp_write && (dest != '0);
            end
          end
        end
        WR_HI: begin
          // odd register is never r0, so no suppression is needed here
          wr_addr <= pend_addr;
          wr_data <= pend_hi;
          fpr_we  <= pend_fp;
          gpr_we  <= !pend_fp;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_writeback_seq.sv
// Directed-vector bench for wb_writeback_seq with hand-computed expectations.
module tb_wb_writeback_seq;

  logic        Clk, Rst;
  logic        in_valid, in_ready;
  logic        reg_write, mem_to_reg, mem_to_reg64, load_byte, jal;
  logic        fp_write, hilo_write, write32_64;
  logic [4:0]  dest;
  logic [31:0] alu_result, mem_data, link_addr;
  logic [63:0] alu64, data64;
  logic        gpr_we, fpr_we, align_err;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data, hi_out, lo_out;

  int n_cmp = 0;
  int n_err = 0;

  wb_writeback_seq dut (
    .Clk(Clk), .Rst(Rst), .in_valid(in_valid), .in_ready(in_ready),
    .reg_write(reg_write), .mem_to_reg(mem_to_reg), .mem_to_reg64(mem_to_reg64),
    .load_byte(load_byte), .jal(jal), .fp_write(fp_write), .hilo_write(hilo_write),
    .write32_64(write32_64), .dest(dest), .alu_result(alu_result), .mem_data(mem_data),
    .link_addr(link_addr), .alu64(alu64), .data64(data64), .gpr_we(gpr_we),
    .fpr_we(fpr_we), .wr_addr(wr_addr), .wr_data(wr_data), .hi_out(hi_out),
    .lo_out(lo_out), .align_err(align_err)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clr();
    in_valid = 0; reg_write = 0; mem_to_reg = 0; mem_to_reg64 = 0; load_byte = 0;
    jal = 0; fp_write = 0; hilo_write = 0; write32_64 = 0; dest = '0;
    alu_result = '0; mem_data = '0; link_addr = '0; alu64 = '0; data64 = '0;
  endtask

  // advance one clock and settle just after the edge; valid only lasts one edge
  task automatic step();
    @(posedge Clk);
    #1;
    in_valid = 0;
  endtask

  initial begin
    clr();
    Rst = 1;
    #12;
    chk("rst_gpr_we", gpr_we, 0);
    chk("rst_fpr_we", fpr_we, 0);
    chk("rst_addr", wr_addr, 0);
    chk("rst_data", wr_data, 0);
    chk("rst_hilo", {hi_out, lo_out}, 0);
    chk("rst_ready", in_ready, 1);
    Rst = 0;
    step();

    // ALU 32-bit
    clr(); in_valid = 1; reg_write = 1; dest = 5; alu_result = 32'h1234;
    step();
    chk("alu_we", {gpr_we, fpr_we}, 2'b10);
    chk("alu_addr", wr_addr, 5);
    chk("alu_data", wr_data, 32'h1234);
    step();
    chk("alu_we_drop", gpr_we, 0);

    // load byte, sign-extended, takes priority over mem_to_reg
    clr(); in_valid = 1; reg_write = 1; mem_to_reg = 1; load_byte = 1;
    mem_data = 32'h000000F0; dest = 3; alu_result = 32'h55;
    step();
    chk("lb_data", wr_data, 32'hFFFFFFF0);
    chk("lb_addr", wr_addr, 3);

    // plain memory word
    clr(); in_valid = 1; reg_write = 1; mem_to_reg = 1; mem_data = 32'hDEADBEEF;
    alu_result = 32'h1; dest = 9;
    step();
    chk("lw_data", wr_data, 32'hDEADBEEF);
    chk("lw_we", gpr_we, 1);

    // 64-bit FPR pair
    clr(); in_valid = 1; reg_write = 1; fp_write = 1; write32_64 = 1; mem_to_reg64 = 1;
    dest = 4; data64 = 64'hAAAA0000_BBBB1111; alu64 = 64'h1;
    step();
    chk("fp64_c1_we", {gpr_we, fpr_we}, 2'b01);
    chk("fp64_c1_addr", wr_addr, 4);
    chk("fp64_c1_data", wr_data, 32'hBBBB1111);
    chk("fp64_c1_ready", in_ready, 0);
    step();
    chk("fp64_c2_we", {gpr_we, fpr_we}, 2'b01);
    chk("fp64_c2_addr", wr_addr, 5);
    chk("fp64_c2_data", wr_data, 32'hAAAA0000);
    chk("fp64_c2_ready", in_ready, 1);
    step();
    chk("fp64_c3_we", {gpr_we, fpr_we}, 2'b00);

    // odd destination for 64-bit: error pulse, nothing written
    clr(); in_valid = 1; reg_write = 1; write32_64 = 1; dest = 7; alu64 = 64'h5_00000006;
    step();
    chk("odd_err", align_err, 1);
    chk("odd_we", {gpr_we, fpr_we}, 2'b00);
    chk("odd_ready", in_ready, 1);
    step();
    chk("odd_err_pulse", align_err, 0);

    // JAL goes to r31 in the GPR file even with fp_write set
    clr(); in_valid = 1; reg_write = 1; jal = 1; fp_write = 1; dest = 2;
    link_addr = 32'h400010; alu_result = 32'h77;
    step();
    chk("jal_we", {gpr_we, fpr_we}, 2'b10);
    chk("jal_addr", wr_addr, 31);
    chk("jal_data", wr_data, 32'h400010);

    // r0 GPR write suppressed
    clr(); in_valid = 1; reg_write = 1; dest = 0; alu_result = 32'h99;
    step();
    chk("r0_we", {gpr_we, fpr_we}, 2'b00);

    // f0 is writable
    clr(); in_valid = 1; reg_write = 1; fp_write = 1; dest = 0; alu_result = 32'h42;
    step();
    chk("f0_we", {gpr_we, fpr_we}, 2'b01);
    chk("f0_data", wr_data, 32'h42);

    // 64-bit GPR pair to r0: low half dropped, high half to r1 kept
    clr(); in_valid = 1; reg_write = 1; write32_64 = 1; dest = 0; alu64 = 64'hCAFE0001_0000BEEF;
    step();
    chk("r0p_c1_we", {gpr_we, fpr_we}, 2'b00);
    chk("r0p_c1_ready", in_ready, 0);
    step();
    chk("r0p_c2_we", {gpr_we, fpr_we}, 2'b10);
    chk("r0p_c2_addr", wr_addr, 1);
    chk("r0p_c2_data", wr_data, 32'hCAFE0001);

    // HI/LO without register write
    clr(); in_valid = 1; hilo_write = 1; alu64 = 64'h1_00000002; dest = 6;
    step();
    chk("hilo", {hi_out, lo_out}, 64'h00000001_00000002);
    chk("hilo_we", {gpr_we, fpr_we}, 2'b00);

    // bubble: nothing changes
    clr(); in_valid = 1; alu64 = 64'hFFFF_FFFF_FFFF_FFFF; dest = 8;
    step();
    chk("bubble_we", {gpr_we, fpr_we, align_err}, 3'b000);
    chk("bubble_hilo", {hi_out, lo_out}, 64'h00000001_00000002);

    // reset while the high half is pending
    clr(); in_valid = 1; reg_write = 1; write32_64 = 1; dest = 2; alu64 = 64'h11112222_33334444;
    step();
    chk("rwh_c1_data", wr_data, 32'h33334444);
    chk("rwh_c1_ready", in_ready, 0);
    Rst = 1;
    #1;
    chk("rwh_rst_ready", in_ready, 1);
    chk("rwh_rst_we", {gpr_we, fpr_we}, 2'b00);
    #2;
    Rst = 0;
    step();
    chk("rwh_after_we", {gpr_we, fpr_we}, 2'b00);
    chk("rwh_after_data", wr_data, 0);
    chk("rwh_after_hilo", {hi_out, lo_out}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
